// File: rtl/d2_5_frame_rx.sv
// ---------------------------------------------------------------------------
// d2_5_frame_rx
//
// Serial receive controller for 2-of-5 coded digit frames. A frame begins
// with a one-cycle sof strobe. After it come NDIGITS data code words and then
// one check code word. Each code word is five bits long and arrives one bit
// at a time, first bit = MSB. The block decodes each word to BCD and keeps a
// running mod-10 checksum. When the frame is complete it holds the result on
// a valid/ready port until the consumer takes it.
//
// Parameters
//   NDIGITS    number of data digits per frame (1..8)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   sof        in   start-of-frame strobe (1 cycle)
//   bit_in     in   serial code bit, sampled when bit_valid=1
//   bit_valid  in   qualifier for bit_in
//   out_ready  in   consumer accepts the held frame
//   out_valid  out  frame is held on the outputs
//   digits     out  data digits, first received digit in [3:0]
//   chk_digit  out  received check digit
//   bad_code   out  at least one code word was not a legal 2-of-5 code
//   frame_ok   out  no bad code and the checksum is correct
//   busy       out  controller is not idle
// ---------------------------------------------------------------------------
module d2_5_frame_rx #(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sof,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [4*NDIGITS-1:0] digits,
  output logic [3:0]           chk_digit,
  output logic                 bad_code,
  output logic                 frame_ok,
  output logic                 busy
);

  // dig_cnt must be able to hold the value NDIGITS. That value selects the
  // check-digit slot.
  localparam int CW = $clog2(NDIGITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      sr;
  logic [2:0]      bit_cnt;
  logic [CW-1:0]   dig_cnt;
  logic [3:0]      sum;

  logic [4:0]      code;
  logic [3:0]      dec_digit;
  logic            dec_illegal;
  logic [4:0]      sum_add;
  logic [3:0]      sum_next;
  logic            bad_next;
  logic            last_digit;

  // The fifth bit of a word is decoded in the same cycle that it arrives, so
  // the code word is the four bits already shifted in plus the live bit_in.
  // An illegal word decodes to 4'hE and adds nothing to the checksum.
  always_comb begin
    code        = {sr[3:0], bit_in};
    dec_digit   = 4'hE;
    dec_illegal = 1'b0;
    case (code)
      5'b01100: dec_digit = 4'd0;
      5'b11000: dec_digit = 4'd1;
      5'b10100: dec_digit = 4'd2;
      5'b10010: dec_digit = 4'd3;
      5'b01010: dec_digit = 4'd4;
      5'b00110: dec_digit = 4'd5;
      5'b10001: dec_digit = 4'd6;
      5'b01001: dec_digit = 4'd7;
      5'b00101: dec_digit = 4'd8;
      5'b00011: dec_digit = 4'd9;
      default:  dec_illegal = 1'b1;
    endcase

    // sum is always 0..9 and the addend is 0..9, so one conditional
    // subtract of 10 is enough to keep the result in range.
    sum_add    = {1'b0, sum} + (dec_illegal ? 5'd0 : {1'b0, dec_digit});
    sum_next   = (sum_add >= 5'd10) ? 4'(sum_add - 5'd10) : sum_add[3:0];
    bad_next   = bad_code | dec_illegal;
    last_digit = (dig_cnt == CW'(NDIGITS));
  end

  // Single-process controller. Every output is a register and is updated
  // together with the state transition that it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      dig_cnt   <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
      digits    <= '0;
      chk_digit <= '0;
      bad_code  <= 1'b0;
      frame_ok  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sof) begin
            bit_cnt  <= '0;
            dig_cnt  <= '0;
            sum      <= '0;
            bad_code <= 1'b0;
            state    <= RECV;
            busy     <= 1'b1;
          end
        end

        RECV: begin
          // A new sof discards the partial frame and starts again. It wins
          // over a bit that arrives in the same cycle.
          if (sof) begin
            bit_cnt  <= '0;
            dig_cnt  <= '0;
            sum      <= '0;
            bad_code <= 1'b0;
            digits   <= '0;
          end else if (bit_valid) begin
            sr <= {sr[2:0], bit_in};
            if (bit_cnt == 3'd4) begin
              bit_cnt  <= '0;
              sum      <= sum_next;
              bad_code <= bad_next;
              if (last_digit) begin
                chk_digit <= dec_digit;
                frame_ok  <= ~bad_next & (sum_next == 4'd0);
                out_valid <= 1'b1;
                state     <= DONE;
              end else begin
                dig_cnt <= dig_cnt + CW'(1);
                for (int i = 0; i < NDIGITS; i++) begin
                  if (dig_cnt == CW'(i)) begin
                    digits[i*4 +: 4] <= dec_digit;
                  end
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

        DONE: begin
          // The frame stays frozen until the consumer takes it. sof and
          // serial bits are ignored while a frame is held.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
